osc_update_scheduler: RTL and testbench

- Sequences one shared oscillator-update datapath across N_SLOTS oscillator slots on every 4 kHz tick from the clock enable generator.
- Each tick opens a frame. For each enabled slot, in ascending index order, the block issues a start/done handshake to the datapath.
- Per-slot watchdog aborts a hung update. Frame overrun is counted when a new tick arrives before the frame completes.

---
 rtl/osc_sched_pkg.sv | 18 +
 rtl/osc_sched_next_slot.sv | 32 +++
 rtl/osc_update_scheduler.sv | 167 ++++++++++++++++
 tb/tb_osc_update_scheduler.sv | 340 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/osc_sched_pkg.sv
// Shared types and default constants for the oscillator update scheduler.
//   sched_state_t      : FSM state encoding (IDLE, ISSUE, WAIT)
//   DEF_N_SLOTS        : default number of oscillator slots
//   DEF_TIMEOUT_CYCLES : default watchdog limit in clk cycles
//   DEF_CNT_W          : default width of the saturating event counters
package osc_sched_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } sched_state_t;

    localparam int DEF_N_SLOTS        = 8;
    localparam int DEF_TIMEOUT_CYCLES = 1024;
    localparam int DEF_CNT_W          = 16;

endpackage

// File: rtl/osc_sched_next_slot.sv
// Combinational priority encoder choosing the next slot to service.
//   mask     : candidate slots
//   cur_idx  : slot currently being serviced
//   first    : 1 = lowest set bit overall, 0 = lowest set bit strictly above cur_idx
//   nxt_idx  : selected slot index
//   valid    : a slot was found
module osc_sched_next_slot
    import osc_sched_pkg::*;
#(
    parameter int N_SLOTS = DEF_N_SLOTS,
    parameter int IDX_W   = (N_SLOTS > 1) ? $clog2(N_SLOTS) : 1
) (
    input  logic [N_SLOTS-1:0] mask,
    input  logic [IDX_W-1:0]   cur_idx,
    input  logic               first,
    output logic [IDX_W-1:0]   nxt_idx,
    output logic               valid
);

    // Descending scan so that the lowest qualifying index is the last write.
    always_comb begin
        nxt_idx = '0;
        valid   = 1'b0;
        for (int i = N_SLOTS - 1; i >= 0; i--) begin
            if (mask[i] && (first || (i > int'(cur_idx)))) begin
                nxt_idx = IDX_W'(i);
                valid   = 1'b1;
            end
        end
    end

endmodule

// File: rtl/osc_update_scheduler.sv
// Shares one oscillator-update datapath across N_SLOTS slots. Each accepted
// tick opens a frame that services every slot enabled in the latched mask,
// lowest index first, with a start/done handshake and a per-slot watchdog.
//   clk, rst          : clock, asynchronous active-high reset
//   tick_en           : frame tick (one cycle)
//   enable            : scheduler enable, looked at only in IDLE
//   slot_mask         : per-slot enable, latched at frame start
//   start, slot_idx   : datapath request and the slot it applies to
//   done              : datapath completion for the current slot
//   busy              : frame in progress
//   frame_done        : frame finished (also for an empty frame)
//   overrun, timeout  : event pulses; overrun_count/timeout_count saturate
//
// state | meaning
// IDLE  | waiting for an enabled tick
// ISSUE | start pulse for slot_idx, watchdog cleared
// WAIT  | waiting for done or the watchdog limit
module osc_update_scheduler
    import osc_sched_pkg::*;
#(
    parameter int N_SLOTS        = DEF_N_SLOTS,
    parameter int IDX_W          = (N_SLOTS > 1) ? $clog2(N_SLOTS) : 1,
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
    parameter int CNT_W          = DEF_CNT_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               tick_en,
    input  logic               enable,
    input  logic [N_SLOTS-1:0] slot_mask,
    output logic               start,
    output logic [IDX_W-1:0]   slot_idx,
    input  logic               done,
    output logic               busy,
    output logic               frame_done,
    output logic               overrun,
    output logic               timeout,
    output logic [CNT_W-1:0]   overrun_count,
    output logic [CNT_W-1:0]   timeout_count
);

    localparam int WD_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

    sched_state_t       state, state_d;
    logic [N_SLOTS-1:0] mask_q, mask_d;
    logic [IDX_W-1:0]   idx_d;
    logic [WD_W-1:0]    wd, wd_d;
    logic               start_d, frame_done_d, overrun_d, timeout_d;
    logic [CNT_W-1:0]   ovr_cnt_d, to_cnt_d;

    logic [N_SLOTS-1:0] enc_mask;
    logic               enc_first;
    logic [IDX_W-1:0]   enc_idx;
    logic               enc_valid;
    logic               wd_limit;

    // In IDLE the search runs over the live mask; during a frame it runs over
    // the latched copy, strictly above the slot just finished.
    assign enc_mask  = (state == IDLE) ? slot_mask : mask_q;
    assign enc_first = (state == IDLE);

    osc_sched_next_slot #(
        .N_SLOTS (N_SLOTS),
        .IDX_W   (IDX_W)
    ) u_next_slot (
        .mask    (enc_mask),
        .cur_idx (slot_idx),
        .first   (enc_first),
        .nxt_idx (enc_idx),
        .valid   (enc_valid)
    );

    // The watchdog is 0 in the first WAIT cycle; the limit is the cycle in
    // which it steps to TIMEOUT_CYCLES-1, so the abort is decided after
    // TIMEOUT_CYCLES-1 WAIT cycles and the timeout pulse lands TIMEOUT_CYCLES
    // cycles after start.
    assign wd_limit = (wd == WD_W'(TIMEOUT_CYCLES - 2));

    always_comb begin
        state_d      = state;
        mask_d       = mask_q;
        idx_d        = slot_idx;
        wd_d         = wd;
        start_d      = 1'b0;
        frame_done_d = 1'b0;
        overrun_d    = 1'b0;
        timeout_d    = 1'b0;
        ovr_cnt_d    = overrun_count;
        to_cnt_d     = timeout_count;

        if (tick_en && (state != IDLE)) begin
            overrun_d = 1'b1;
            if (overrun_count != '1) begin
                ovr_cnt_d = overrun_count + 1'b1;
            end
        end

        case (state)
            IDLE: begin
                if (tick_en && enable) begin
                    mask_d = slot_mask;
                    if (enc_valid) begin
                        idx_d   = enc_idx;
                        state_d = ISSUE;
                        start_d = 1'b1;
                    end else begin
                        frame_done_d = 1'b1;
                    end
                end
            end
            ISSUE: begin
                state_d = WAIT;
                wd_d    = '0;
            end
            WAIT: begin
                wd_d = wd + 1'b1;
                if (done || wd_limit) begin
                    if (!done) begin
                        timeout_d = 1'b1;
                        if (timeout_count != '1) begin
                            to_cnt_d = timeout_count + 1'b1;
                        end
                    end
                    mask_d = mask_q & ~(N_SLOTS'(1) << slot_idx);
                    if (enc_valid) begin
                        idx_d   = enc_idx;
                        state_d = ISSUE;
                        start_d = 1'b1;
                    end else begin
                        state_d      = IDLE;
                        frame_done_d = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            mask_q        <= '0;
            slot_idx      <= '0;
            wd            <= '0;
            start         <= 1'b0;
            busy          <= 1'b0;
            frame_done    <= 1'b0;
            overrun       <= 1'b0;
            timeout       <= 1'b0;
            overrun_count <= '0;
            timeout_count <= '0;
        end else begin
            state         <= state_d;
            mask_q        <= mask_d;
            slot_idx      <= idx_d;
            wd            <= wd_d;
            start         <= start_d;
            busy          <= (state_d != IDLE);
            frame_done    <= frame_done_d;
            overrun       <= overrun_d;
            timeout       <= timeout_d;
            overrun_count <= ovr_cnt_d;
            timeout_count <= to_cnt_d;
        end
    end

endmodule

// File: tb/tb_osc_update_scheduler.sv
// Self-checking bench for osc_update_scheduler (4 slots, 16-cycle watchdog,
// 2-bit counters). Expected slot order is queued when a frame is ticked and
// compared by a monitor whenever start is seen.
module tb_osc_update_scheduler;

    localparam int N_SLOTS = 4;
    localparam int IDX_W   = 2;
    localparam int TOUT    = 16;
    localparam int CNT_W   = 2;

    logic               clk = 1'b0;
    logic               rst;
    logic               tick_en;
    logic               enable;
    logic [N_SLOTS-1:0] slot_mask;
    logic               start;
    logic [IDX_W-1:0]   slot_idx;
    logic               done;
    logic               busy;
    logic               frame_done;
    logic               overrun;
    logic               timeout;
    logic [CNT_W-1:0]   overrun_count;
    logic [CNT_W-1:0]   timeout_count;

    int checks   = 0;
    int failures = 0;
    int exp_q[$];

    osc_update_scheduler #(
        .N_SLOTS        (N_SLOTS),
        .IDX_W          (IDX_W),
        .TIMEOUT_CYCLES (TOUT),
        .CNT_W          (CNT_W)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .tick_en       (tick_en),
        .enable        (enable),
        .slot_mask     (slot_mask),
        .start         (start),
        .slot_idx      (slot_idx),
        .done          (done),
        .busy          (busy),
        .frame_done    (frame_done),
        .overrun       (overrun),
        .timeout       (timeout),
        .overrun_count (overrun_count),
        .timeout_count (timeout_count)
    );

    always #4 clk = ~clk;

    // Scoreboard: every start must match the next expected slot.
    always @(negedge clk) begin
        if (rst === 1'b0 && start === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL sb_unexpected_start: got slot %0d expected no start", slot_idx);
            end else begin
                int e;
                e = exp_q.pop_front();
                if (slot_idx !== IDX_W'(e)) begin
                    failures++;
                    $display("FAIL sb_slot_order: got slot %0d expected %0d", slot_idx, e);
                end
            end
        end
    end

    task automatic step();
        @(negedge clk);
    endtask

    task automatic push_frame(input logic [N_SLOTS-1:0] m);
        for (int i = 0; i < N_SLOTS; i++) begin
            if (m[i]) exp_q.push_back(i);
        end
    endtask

    // Called at the negedge where start is visible; returns at the negedge
    // one cycle after done was sampled.
    task automatic serve(input int delay);
        repeat (delay) step();
        done = 1'b1;
        step();
        done = 1'b0;
    endtask

    task automatic fire_tick(input logic [N_SLOTS-1:0] m);
        slot_mask = m;
        tick_en   = 1'b1;
        step();
        tick_en   = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; tick_en = 1'b0; enable = 1'b1; slot_mask = '0; done = 1'b0;
        repeat (2) step();
        checks++;
        if ({start, busy, frame_done, overrun, timeout} !== 5'b0 || slot_idx !== '0 ||
            overrun_count !== '0 || timeout_count !== '0) begin
            failures++;
            $display("FAIL reset_values: got start=%b busy=%b fd=%b ov=%b to=%b idx=%0d oc=%0d tc=%0d expected all 0",
                     start, busy, frame_done, overrun, timeout, slot_idx, overrun_count, timeout_count);
        end
        rst = 1'b0;
        step();
    endtask

    task automatic test_basic_frame();
        push_frame(4'b1011);
        fire_tick(4'b1011);
        checks++;
        if (start !== 1'b1 || busy !== 1'b1) begin
            failures++;
            $display("FAIL t1_start_latency: got start=%b busy=%b expected 1 1", start, busy);
        end
        for (int k = 0; k < 2; k++) begin
            serve(3);
            checks++;
            if (start !== 1'b1) begin
                failures++;
                $display("FAIL t1_start_after_done: got start=%b expected 1 (slot %0d)", start, k + 1);
            end
        end
        serve(3);
        checks++;
        if (frame_done !== 1'b1 || busy !== 1'b0 || start !== 1'b0) begin
            failures++;
            $display("FAIL t1_frame_done: got fd=%b busy=%b start=%b expected 1 0 0", frame_done, busy, start);
        end
        step();
        checks++;
        if (frame_done !== 1'b0) begin
            failures++;
            $display("FAIL t1_frame_done_width: got fd=%b expected 0", frame_done);
        end
    endtask

    task automatic test_empty_frame();
        fire_tick(4'b0000);
        checks++;
        if (frame_done !== 1'b1 || busy !== 1'b0 || start !== 1'b0) begin
            failures++;
            $display("FAIL t2_empty_frame: got fd=%b busy=%b start=%b expected 1 0 0", frame_done, busy, start);
        end
        enable = 1'b0;
        fire_tick(4'b1111);
        enable = 1'b1;
        repeat (3) begin
            checks++;
            if (frame_done !== 1'b0 || busy !== 1'b0 || start !== 1'b0 || overrun !== 1'b0) begin
                failures++;
                $display("FAIL t2_disabled_tick: got fd=%b busy=%b start=%b ov=%b expected 0 0 0 0",
                         frame_done, busy, start, overrun);
            end
            step();
        end
    endtask

    task automatic test_timeout();
        bit early;
        early = 1'b0;
        push_frame(4'b0011);
        fire_tick(4'b0011);
        serve(3);                       // now at the slot-1 start
        for (int k = 1; k < TOUT; k++) begin
            step();
            if (timeout !== 1'b0) early = 1'b1;
        end
        checks++;
        if (early) begin
            failures++;
            $display("FAIL t3_timeout_early: got timeout before cycle %0d expected none", TOUT);
        end
        step();                         // start + TOUT
        checks++;
        if (timeout !== 1'b1 || timeout_count !== 2'd1 || frame_done !== 1'b1 || busy !== 1'b0) begin
            failures++;
            $display("FAIL t3_timeout: got to=%b tc=%0d fd=%b busy=%b expected 1 1 1 0",
                     timeout, timeout_count, frame_done, busy);
        end
        step();
        checks++;
        if (timeout !== 1'b0) begin
            failures++;
            $display("FAIL t3_timeout_width: got to=%b expected 0", timeout);
        end
        // done arriving in the limit cycle wins
        push_frame(4'b0011);
        fire_tick(4'b0011);
        serve(3);
        serve(TOUT - 1);
        checks++;
        if (timeout !== 1'b0 || timeout_count !== 2'd1 || frame_done !== 1'b1) begin
            failures++;
            $display("FAIL t3_done_wins: got to=%b tc=%0d fd=%b expected 0 1 1", timeout, timeout_count, frame_done);
        end
    endtask

    task automatic test_overrun();
        push_frame(4'b1011);
        fire_tick(4'b1011);
        tick_en = 1'b1;                 // tick during ISSUE
        step();
        tick_en = 1'b0;
        checks++;
        if (overrun !== 1'b1 || overrun_count !== 2'd1) begin
            failures++;
            $display("FAIL t4_overrun: got ov=%b oc=%0d expected 1 1", overrun, overrun_count);
        end
        serve(2);
        checks++;
        if (start !== 1'b1 || overrun !== 1'b0) begin
            failures++;
            $display("FAIL t4_frame_continues: got start=%b ov=%b expected 1 0", start, overrun);
        end
        serve(3);
        serve(3);
        checks++;
        if (frame_done !== 1'b1 || busy !== 1'b0) begin
            failures++;
            $display("FAIL t4_frame_end: got fd=%b busy=%b expected 1 0", frame_done, busy);
        end
        repeat (4) step();
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL t4_no_second_frame: got busy=%b expected 0", busy);
        end
        // saturation: 5 more overruns on a 2-bit counter
        push_frame(4'b1000);
        slot_mask = 4'b1000;
        tick_en   = 1'b1;
        step();
        repeat (5) step();
        tick_en = 1'b0;
        checks++;
        if (overrun_count !== 2'd3) begin
            failures++;
            $display("FAIL t4_saturate: got oc=%0d expected 3", overrun_count);
        end
        done = 1'b1;
        step();
        done = 1'b0;
        checks++;
        if (frame_done !== 1'b1 || overrun_count !== 2'd3) begin
            failures++;
            $display("FAIL t4_saturate_hold: got fd=%b oc=%0d expected 1 3", frame_done, overrun_count);
        end
    endtask

    task automatic test_ignore_and_boundary();
        done = 1'b1;
        repeat (2) step();
        done = 1'b0;
        checks++;
        if (busy !== 1'b0 || start !== 1'b0 || frame_done !== 1'b0) begin
            failures++;
            $display("FAIL t5_stray_done: got busy=%b start=%b fd=%b expected 0 0 0", busy, start, frame_done);
        end
        push_frame(4'b0101);
        fire_tick(4'b0101);
        slot_mask = 4'b0010;            // change after latch: must not matter
        serve(3);
        serve(3);
        checks++;
        if (frame_done !== 1'b1) begin
            failures++;
            $display("FAIL t5_latched_frame_end: got fd=%b expected 1", frame_done);
        end
        push_frame(4'b0010);
        fire_tick(4'b0010);             // tick in the frame_done cycle
        checks++;
        if (start !== 1'b1 || overrun !== 1'b0) begin
            failures++;
            $display("FAIL t5_boundary_tick: got start=%b ov=%b expected 1 0", start, overrun);
        end
        serve(3);
        checks++;
        if (frame_done !== 1'b1) begin
            failures++;
            $display("FAIL t5_boundary_frame_end: got fd=%b expected 1", frame_done);
        end
    endtask

    task automatic test_reset_mid();
        push_frame(4'b0110);
        fire_tick(4'b0110);
        repeat (2) step();              // in WAIT for slot 1
        rst = 1'b1;
        #1;
        checks++;
        if ({start, busy, frame_done, overrun, timeout} !== 5'b0 || slot_idx !== '0 ||
            overrun_count !== '0 || timeout_count !== '0) begin
            failures++;
            $display("FAIL t6_async_reset: got start=%b busy=%b fd=%b ov=%b to=%b idx=%0d oc=%0d tc=%0d expected all 0",
                     start, busy, frame_done, overrun, timeout, slot_idx, overrun_count, timeout_count);
        end
        exp_q.delete();
        step();
        rst = 1'b0;
        step();
        push_frame(4'b0110);
        fire_tick(4'b0110);
        checks++;
        if (start !== 1'b1 || slot_idx !== 2'd1) begin
            failures++;
            $display("FAIL t6_restart: got start=%b idx=%0d expected 1 1", start, slot_idx);
        end
        serve(3);
        serve(3);
        checks++;
        if (frame_done !== 1'b1 || busy !== 1'b0) begin
            failures++;
            $display("FAIL t6_frame_end: got fd=%b busy=%b expected 1 0", frame_done, busy);
        end
    endtask

    initial begin
        test_reset();
        test_basic_frame();
        test_empty_frame();
        test_timeout();
        test_overrun();
        test_ignore_and_boundary();
        test_reset_mid();
        repeat (2) step();
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL sb_drain: got %0d pending starts expected 0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
